// File: rtl/mem_spi_drain.sv
// Drains LEN bytes from a byte buffer (address 0 upward) out over a mode-0 SPI master port.
// Optional MISO receive path is enabled by defining MISO_CAPTURE_EN.
module mem_spi_drain #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DEPTH   = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [5:0] LEN,
    input  logic       ABORT,
    input  logic [7:0] BYTEIN,
    output logic [4:0] ADDR,
    output logic       READ,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_N,
    output logic       BUSY,
`ifdef MISO_CAPTURE_EN
    input  logic       MISO,
    output logic [7:0] RXBYTE,
    output logic       RXVALID,
`endif
    output logic       DONE
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StStrobe, StLatch, StShift, StFinish
    } state_e;

    localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
    localparam logic [5:0] DepthLen = 6'(DEPTH);
    localparam logic [4:0] IdxLast  = 5'(DEPTH - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] div_q, div_d;
    logic [3:0] half_q, half_d;   // SCLK half-period index; odd = high phase
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            div_q   <= '0;
            half_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            half_q  <= half_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        div_d   = div_q;
        half_d  = half_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (busy_q) begin
                    // Single BUSY cycle of a zero-length transfer
                    busy_d = 1'b0;
                end else if (START) begin
                    busy_d = 1'b1;
                    idx_d  = '0;
                    cnt_d  = (LEN > DepthLen) ? DepthLen : LEN;
                    if (LEN == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch:  state_d = StStrobe;
            StStrobe: state_d = StLatch;
            StLatch: begin
                sh_d    = BYTEIN;
                div_d   = '0;
                half_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (half_q == 4'd15) begin
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q != 6'd1) begin
                            idx_d   = (idx_q == IdxLast) ? 5'd0 : idx_q + 5'd1;
                            state_d = StFetch;
                        end else begin
                            state_d = StFinish;
                        end
                    end else begin
                        half_d = half_q + 4'd1;
                        // End of a high phase: next bit appears on the falling edge
                        if (half_q[0]) begin
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StFinish: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort is ignored in IDLE and must not restart an ongoing FINISH
        if (ABORT && (state_q != StIdle) && (state_q != StFinish)) begin
            state_d = StFinish;
            div_d   = '0;
        end
    end

    assign ADDR = idx_q;
    assign READ = (state_q == StStrobe);
    assign SCLK = (state_q == StShift) && half_q[0];
    assign MOSI = (state_q == StLatch) ? BYTEIN[7] : sh_q[7];
    assign CS_N = (state_q == StIdle);
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef MISO_CAPTURE_EN
    logic [7:0] rx_sh_q;
    logic [7:0] rxbyte_q;
    logic       rxvalid_q;
    logic       sclk_rise;

    // SCLK goes high on this edge unless the abort pulls the state into FINISH
    assign sclk_rise = (state_q == StShift) && !half_q[0] && (div_q == DivLast) && !ABORT;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_sh_q   <= '0;
            rxbyte_q  <= '0;
            rxvalid_q <= 1'b0;
        end else begin
            rxvalid_q <= 1'b0;
            if (sclk_rise) begin
                rx_sh_q <= {rx_sh_q[6:0], MISO};
                if (half_q == 4'd14) begin
                    rxbyte_q  <= {rx_sh_q[6:0], MISO};
                    rxvalid_q <= 1'b1;
                end
            end
        end
    end

    assign RXBYTE  = rxbyte_q;
    assign RXVALID = rxvalid_q;
`endif

endmodule

// File: tb/tb_mem_spi_drain.sv
// Scoreboard bench for mem_spi_drain: expected reads, MOSI bytes and DONE times are queued
// by the stimulus and popped by a negedge monitor.
module tb_mem_spi_drain;

    localparam int D   = 2;
    localparam int DEP = 32;
    localparam int B   = 3 + 16 * D;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [5:0] LEN = '0;
    logic [7:0] BYTEIN = '0;
    logic [4:0] ADDR;
    logic       READ, SCLK, MOSI, CS_N, BUSY, DONE;
`ifdef MISO_CAPTURE_EN
    logic       MISO = 1'b0;
    logic [7:0] RXBYTE;
    logic       RXVALID;
`endif

    logic [7:0] mem [DEP];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int exp_addr[$];
    int exp_rcyc[$];
    int exp_byte[$];
    int exp_done[$];

    mem_spi_drain #(.CLK_DIV(D), .DEPTH(DEP)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .LEN    (LEN),
        .ABORT  (ABORT),
        .BYTEIN (BYTEIN),
        .ADDR   (ADDR),
        .READ   (READ),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .CS_N   (CS_N),
        .BUSY   (BUSY),
`ifdef MISO_CAPTURE_EN
        .MISO   (MISO),
        .RXBYTE (RXBYTE),
        .RXVALID(RXVALID),
`endif
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    // Buffer model: samples ADDR while READ is high
    always @(posedge CLK) if (READ) BYTEIN <= mem[ADDR];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic flag(input string nm, input int act);
        n_checks++;
        $display("FAIL %s: got event with value %0d, expected none", nm, act);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEP; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, ADDR, 0);
        check({tag, "_read"}, READ, 0);
        check({tag, "_sclk"}, SCLK, 0);
        check({tag, "_mosi"}, MOSI, 0);
        check({tag, "_cs_n"}, CS_N, 1);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
    endtask

    // Reference: n = min(len, DEP) bytes, byte k read at c+2+kB, DONE at c+1+nB+D (c+1 if n=0)
    task automatic start_xfer(input int len, input bit with_abort, output int c);
        int n;
        n = (len > DEP) ? DEP : len;
        c = cyc;
        START = 1'b1;
        LEN   = 6'(len);
        ABORT = with_abort;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(k % DEP);
            exp_rcyc.push_back(c + 2 + k * B);
            exp_byte.push_back(int'(mem[k % DEP]));
        end
        exp_done.push_back((n == 0) ? c + 1 : c + 1 + n * B + D);
        step();
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic wait_quiet(input int limit);
        int t;
        t = 0;
        while ((BUSY || exp_done.size() != 0) && t < limit) begin
            step();
            t++;
        end
        if (t >= limit) flag("timeout_waiting_done", t);
        step();
        check("queues_drained", exp_addr.size() + exp_byte.size() + exp_done.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a full byte or DONE
    initial begin : monitor
        logic       prev;
        int         nb;
        logic [7:0] acc;
        prev = 1'b0;
        nb   = 0;
        acc  = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                nb   = 0;
                prev = 1'b0;
            end else begin
                if (READ) begin
                    if (exp_addr.size() == 0) flag("read_unexpected", ADDR);
                    else begin
                        check("read_addr", ADDR, exp_addr.pop_front());
                        check("read_cycle", cyc, exp_rcyc.pop_front());
                    end
                end
                if (CS_N) nb = 0;
                else if (SCLK && !prev) begin
                    acc = {acc[6:0], MOSI};
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        if (exp_byte.size() == 0) flag("mosi_byte_unexpected", acc);
                        else check("mosi_byte", acc, exp_byte.pop_front());
                    end
                end
                if (DONE) begin
                    if (exp_done.size() == 0) flag("done_unexpected", cyc);
                    else check("done_cycle", cyc, exp_done.pop_front());
                end
                prev = SCLK;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, a, hi, rises, len, t;
        logic prev;

        fill_mem();
        #2;
        check_reset_outputs("reset");
        step();
        step();
        RESET = 1'b0;
        step();
        check_reset_outputs("idle_after_reset");

        // Two-byte directed transfer; CS_N must stay low across both bytes
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        start_xfer(2, 1'b0, c);
        hi = 0;
        for (int i = 0; i < 2 * B + D; i++) begin
            if (CS_N) hi++;
            step();
        end
        check("cs_low_throughout", hi, 0);
        wait_quiet(200);

        // Zero length: one BUSY cycle, DONE next cycle, no SPI activity
        start_xfer(0, 1'b0, c);
        check("len0_busy_c1", BUSY, 1);
        hi = 0;
        if (!CS_N) hi++;
        step();
        check("len0_busy_c2", BUSY, 0);
        for (int i = 0; i < 4; i++) begin
            if (!CS_N) hi++;
            step();
        end
        check("len0_cs_never_low", hi, 0);
        wait_quiet(20);

        // Saturated length
        fill_mem();
        start_xfer(40, 1'b0, c);
        wait_quiet(2000);

        // Random transfers; some with ABORT alongside START, one with a START while busy
        for (int r = 0; r < 6; r++) begin
            fill_mem();
            len = $urandom_range(1, 5);
            start_xfer(len, ($urandom_range(0, 2) == 0), c);
            if (r == 0) begin
                repeat (20) step();
                START = 1'b1;
                LEN   = 6'd5;
                step();
                START = 1'b0;
            end
            wait_quiet(400);
        end

        // Abort in the 4th SCLK high phase of byte 0
        fill_mem();
        c = cyc;
        START = 1'b1;
        LEN   = 6'd3;
        exp_addr.push_back(0);
        exp_rcyc.push_back(c + 2);
        step();
        START = 1'b0;
        rises = 0;
        prev  = 1'b0;
        t     = 0;
        while (rises < 4 && t < 200) begin
            if (SCLK && !prev) rises++;
            prev = SCLK;
            if (rises < 4) step();
            t++;
        end
        if (rises < 4) flag("abort_no_4th_rise", rises);
        a = cyc;
        ABORT = 1'b1;
        exp_done.push_back(a + 1 + D);
        step();
        ABORT = 1'b0;
        check("abort_sclk_low", SCLK, 0);
        check("abort_read_low", READ, 0);
        repeat (D - 1) step();
        check("abort_cs_still_low", CS_N, 0);
        step();
        check("abort_cs_high", CS_N, 1);
        check("abort_done", DONE, 1);
        wait_quiet(50);

        // Reset in the middle of SHIFT abandons the transfer without DONE
        fill_mem();
        start_xfer(2, 1'b0, c);
        t = 0;
        while (!SCLK && t < 100) begin
            step();
            t++;
        end
        check("reset_reached_shift", SCLK, 1);
        repeat (3) step();
        RESET = 1'b1;
        exp_addr.delete();
        exp_rcyc.delete();
        exp_byte.delete();
        exp_done.delete();
        #1;
        check_reset_outputs("midshift_reset");
        step();
        step();
        RESET = 1'b0;
        step();
        start_xfer(1, 1'b0, c);
        wait_quiet(100);

        check("final_queues", exp_addr.size() + exp_rcyc.size() + exp_byte.size()
              + exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_spi_drain.md
MEM_SPI_DRAIN -- requirements
Module: MEM_SPI_DRAIN

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and RESET.
REQ-002 Parameter CLK_DIV, default 4: CLK cycles per SCLK half-period; legal range 1..255.
REQ-003 Parameter DEPTH, default 32: buffer depth in bytes, and the LEN saturation limit.
REQ-004 CLK  in  1  system clock; all state updates on the rising edge.
REQ-005 RESET  in  1  asynchronous active-high reset.
REQ-006 START  in  1  one-cycle request to drain LEN bytes from buffer address 0 upward.
REQ-007 LEN  in  6  byte count, sampled only on an accepted START.
REQ-008 ABORT  in  1  synchronous request to end the transfer early.
REQ-009 BYTEIN  in  8  read data from the 32-byte buffer.
REQ-010 ADDR  out  5  buffer read address.
REQ-011 READ  out  1  buffer read strobe; the buffer samples ADDR on its rising edge.
REQ-012 SCLK  out  1  SPI clock, mode 0 (idle low).
REQ-013 MOSI  out  1  SPI data out, MSB first.
REQ-014 CS_N  out  1  SPI chip select, active low.
REQ-015 BUSY  out  1  high from START acceptance until DONE.
REQ-016 DONE  out  1  one-cycle pulse when a transfer ends, whether complete or aborted.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, STROBE, LATCH, SHIFT and FINISH.
REQ-018 IDLE: START with BUSY=0 SHALL be accepted.
- LEN latched into a byte counter; LEN>DEPTH saturates to DEPTH.
- Byte index cleared; BUSY set.
- Go to FETCH.
REQ-019 START while BUSY=1 SHALL be ignored, with no effect on the transfer in progress.
REQ-020 START with LEN=0 SHALL produce no SPI activity: CS_N stays high, DONE pulses the next cycle, BUSY high for exactly 1 cycle.
REQ-021 FETCH (1 cycle) SHALL drive ADDR to the byte index, with READ=0 and CS_N=0.
REQ-022 STROBE (1 cycle) SHALL hold ADDR and drive READ=1.
REQ-023 LATCH (1 cycle) SHALL drive READ=0, load BYTEIN into an 8-bit shift register, and drive MOSI with bit 7.
REQ-024 SHIFT SHALL run 8 SCLK periods.
- Each period: SCLK low CLK_DIV cycles, then high CLK_DIV cycles.
- MOSI changes only on the SCLK falling edge or on LATCH entry.
REQ-025 At the end of the 8th high phase, SCLK SHALL return low and the counter SHALL decrement.
- Nonzero remainder: index increments, go to FETCH.
- Zero remainder: go to FINISH.
REQ-026 Per-byte latency SHALL be exactly 3+16*CLK_DIV cycles, FETCH entry to FETCH entry.
REQ-027 CS_N SHALL stay low between bytes of one transfer.
REQ-028 FINISH SHALL hold SCLK=0 and CS_N=0 for CLK_DIV cycles, then set CS_N=1, pulse DONE, clear BUSY and go to IDLE.
REQ-029 The byte index SHALL wrap from DEPTH-1 to 0; with LEN saturated this wrap is unreachable.
REQ-030 ABORT in any non-IDLE state SHALL force SCLK=0 and READ=0 next cycle and enter FINISH; ABORT in IDLE is ignored.
REQ-031 ABORT and START together in IDLE SHALL result in START accepted and ABORT ignored.
REQ-032 ABORT during FINISH SHALL NOT restart or extend FINISH.

Reset
REQ-033 RESET high SHALL asynchronously force the following, regardless of state:
- State IDLE.
- ADDR=0, READ=0, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0.
- Counter, index and shift register = 0.
REQ-034 Reset during a transfer SHALL abandon it with no DONE pulse, and the first START after RESET falls SHALL be accepted normally.

Configuration
REQ-035 Macro MISO_CAPTURE_EN, when defined, SHALL add the following:
- Input MISO (1).
- Output RXBYTE (8), reset value 0.
- Output RXVALID (1), reset value 0.
- MISO sampled on each SCLK rising edge, MSB first.
- After the 8th rising edge of a byte, RXBYTE is updated and RXVALID pulses for 1 cycle.
- An aborted partial byte produces no RXVALID.
REQ-036 Without MISO_CAPTURE_EN, the MISO, RXBYTE and RXVALID ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-037 CLK_DIV=2, buffer [0]=0xA5 [1]=0x3C, START with LEN=2 -> the following response:
- READ pulses at ADDR 0 then 1.
- MOSI bits 10100101 then 00111100.
- Byte starts 35 cycles apart.
- CS_N low throughout; DONE 1 cycle.
REQ-038 START with LEN=0 -> CS_N never low, DONE one cycle after START, no READ pulse.
REQ-039 START with LEN=40 -> exactly 32 bytes from ADDR 0..31, 32 READ pulses, no wrap.
REQ-040 ABORT during the 4th SCLK high phase of byte 0 -> the following response:
- SCLK low the next cycle.
- CS_N high CLK_DIV cycles later.
- DONE pulse; no further READ.
REQ-041 RESET asserted mid-SHIFT -> all outputs at reset values in the same cycle with no DONE; a new START with LEN=1 then completes normally.
REQ-042 With MISO_CAPTURE_EN, MISO driven as 0x5A during one byte -> RXBYTE=0x5A with a single RXVALID pulse after the 8th rising SCLK edge.
